// File: rtl/key_debounce_pkg.sv
// Shared constants for the multi-channel key debouncer: state encoding and
// default 50 MHz timing values.
package key_debounce_pkg;

    localparam logic [0:0] ST_REL = 1'b0;
    localparam logic [0:0] ST_PRS = 1'b1;

    localparam int unsigned DEB_20MS = 999_999;
    localparam int unsigned LONG_1S  = 49_999_999;

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key bundle between board pins and control logic. There is no valid/ready
// handshake: key_in is a raw level, key_level a level, press/release/long are
// single-cycle pulses the consumer must sample on every clock.
interface key_debounce_multi_if #(
    parameter int unsigned NUM_KEYS = 4
);

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_level, key_press, key_release, key_long
    );

    modport slave (
        input  key_in,
        output key_level, key_press, key_release, key_long
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, REL/PRS state machine with stable
// counter, registered pulses. Long-press detection built only with KEY_LONG_PRESS_EN.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned CNT_MAX    = DEB_20MS,
    parameter int unsigned LONG_MAX   = LONG_1S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [0:0] state_dbg
);

    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic        REL_LVL = (ACTIVE_LOW != 0);

    logic             sync1;
    logic             sync2;
    logic             s;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    // Normalised sample: 1 = pressed regardless of pin polarity.
    assign s = sync2 ^ REL_LVL;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= REL_LVL;
            sync2       <= REL_LVL;
            state       <= ST_REL;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (s == state[0]) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CNT_MAX)) begin
                cnt         <= '0;
                state       <= ~state;
                key_press   <= (state == ST_REL);
                key_release <= (state == ST_PRS);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign key_level = (state == ST_PRS);
    assign state_dbg = state;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LONG_W = cnt_width(LONG_MAX);

    logic [LONG_W-1:0] lc;
    logic              long_done;
    logic              long_r;

    // long_done blocks a repeat pulse while the key stays held past LONG_MAX.
    always_ff @(posedge clk) begin
        if (rst || state == ST_REL) begin
            lc        <= '0;
            long_done <= 1'b0;
            long_r    <= 1'b0;
        end else begin
            long_r <= 1'b0;
            if (lc != LONG_W'(LONG_MAX)) begin
                lc <= lc + LONG_W'(1);
            end else if (!long_done) begin
                long_r    <= 1'b1;
                long_done <= 1'b1;
            end
        end
    end

    assign key_long = long_r;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer top: NUM_KEYS independent key_debounce_ch instances.
// Define KEY_LONG_PRESS_EN to enable the per-channel long-press pulse.
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned CNT_MAX    = DEB_20MS,
    parameter int unsigned LONG_MAX   = LONG_1S
) (
    input  logic                clk,
    input  logic                rst,
    key_debounce_multi_if.slave bus,
    output logic [NUM_KEYS-1:0] state_dbg
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .CNT_MAX    (CNT_MAX),
            .LONG_MAX   (LONG_MAX)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_in      (bus.key_in[i]),
            .key_level   (bus.key_level[i]),
            .key_press   (bus.key_press[i]),
            .key_release (bus.key_release[i]),
            .key_long    (bus.key_long[i]),
            .state_dbg   (state_dbg[i:i])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random key traffic,
// checked against a sliding-window reference model of the debounce rules.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int CM = 9;
  localparam int LM = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NK-1:0] state_dbg;

  key_debounce_multi_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .CNT_MAX(CM), .LONG_MAX(LM)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a channel flips when the last CM+1 synchronised samples
  // (taken two edges late) all disagree with its current level.
  logic [NK-1:0] exp_q[$];
  logic [NK-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
  int cyc = 0;
  int press_cyc[NK];

  always @(posedge clk) begin
    logic [NK-1:0] prev;
    logic all_on, all_off;
    cyc++;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < CM + 3; k++) exp_q.push_back('0);
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    end else begin
      exp_q.push_back(~bus.key_in);
      void'(exp_q.pop_front());
      prev = m_level;
      for (int ch = 0; ch < NK; ch++) begin
        all_on = 1'b1; all_off = 1'b1;
        for (int k = 0; k <= CM; k++) begin
          if (exp_q[k][ch]) all_off = 1'b0;
          else all_on = 1'b0;
        end
        m_press[ch] = !prev[ch] && all_on;
        m_rel[ch]   = prev[ch] && all_off;
`ifdef KEY_LONG_PRESS_EN
        m_long[ch]  = prev[ch] && (cyc - press_cyc[ch] == LM + 1);
`else
        m_long[ch]  = 1'b0;
`endif
        if (m_press[ch]) press_cyc[ch] = cyc;
        m_level[ch] = prev[ch] ^ (m_press[ch] | m_rel[ch]);
      end
    end
  end

  task automatic drive_keys(input logic [NK-1:0] v);
    @(negedge clk);
    bus.key_in = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_in = '1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b lng=%b st=%b want all 0",
               bus.key_level, bus.key_press, bus.key_release, bus.key_long, state_dbg);
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !== '0) begin
        n_fail++;
        $display("FAIL reset_exit got lvl=%b prs=%b rel=%b lng=%b want all 0",
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long);
      end
    end
  endtask

  task automatic test_press_latency();
    int first = -1, cnt = 0, lvl_at = 0;
    drive_keys(4'b1110);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !==
          {m_level, m_press, m_rel, m_long}) begin
        n_fail++;
        $display("FAIL press_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long,
                 m_level, m_press, m_rel, m_long);
      end
      if (bus.key_press[0]) begin
        cnt++;
        if (first < 0) begin first = k; lvl_at = int'(bus.key_level[0]); end
      end
    end
    n_cmp++;
    if (first != 12 || cnt != 1 || lvl_at != 1) begin
      n_fail++;
      $display("FAIL press_latency got edge=%0d pulses=%0d level=%0d want edge=12 pulses=1 level=1",
               first, cnt, lvl_at);
    end
    drive_keys(4'b1111);
    repeat (15) @(negedge clk);
  endtask

  task automatic test_bounce();
    int seen = 0;
    for (int r = 0; r < 5; r++) begin
      drive_keys(4'b1101);
      repeat (7) @(negedge clk);
      bus.key_in = 4'b1111;
      repeat (8) begin
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !==
            {m_level, m_press, m_rel, m_long}) begin
          n_fail++;
          $display("FAIL bounce_model got %b/%b/%b/%b want %b/%b/%b/%b",
                   bus.key_level, bus.key_press, bus.key_release, bus.key_long,
                   m_level, m_press, m_rel, m_long);
        end
        if (bus.key_press[1] || bus.key_level[1]) seen++;
      end
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL bounce_no_press got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_release();
    int first = -1, lvl_at = 1;
    drive_keys(4'b1011);
    repeat (32) @(negedge clk);
    bus.key_in = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !==
          {m_level, m_press, m_rel, m_long}) begin
        n_fail++;
        $display("FAIL release_model got %b/%b/%b/%b want %b/%b/%b/%b",
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long,
                 m_level, m_press, m_rel, m_long);
      end
      if (bus.key_release[2] && first < 0) begin first = k; lvl_at = int'(bus.key_level[2]); end
    end
    n_cmp++;
    if (first != 12 || lvl_at != 0) begin
      n_fail++;
      $display("FAIL release_latency got edge=%0d level=%0d want edge=12 level=0", first, lvl_at);
    end
  endtask

  task automatic test_simultaneous();
    int hit = 0;
    drive_keys(4'b0000);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 12) begin
        n_cmp++;
        if ({bus.key_press, bus.key_release, bus.key_long, bus.key_level} !== {4'hF, 4'h0, 4'h0, 4'hF}) begin
          n_fail++;
          $display("FAIL simultaneous got prs=%b rel=%b lng=%b lvl=%b want 1111/0000/0000/1111",
                   bus.key_press, bus.key_release, bus.key_long, bus.key_level);
        end
      end
      if (bus.key_press != 4'h0) hit++;
    end
    n_cmp++;
    if (hit != 1) begin
      n_fail++;
      $display("FAIL simultaneous_once got %0d press cycles want 1", hit);
    end
    drive_keys(4'b1111);
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid_count();
    int first = -1;
    drive_keys(4'b1110);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid got %b/%b/%b/%b want all 0",
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !==
          {m_level, m_press, m_rel, m_long}) begin
        n_fail++;
        $display("FAIL reset_mid_model got %b/%b/%b/%b want %b/%b/%b/%b",
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long,
                 m_level, m_press, m_rel, m_long);
      end
      if (bus.key_press[0] && first < 0) first = k;
    end
    n_cmp++;
    if (first != 12) begin
      n_fail++;
      $display("FAIL reset_mid_latency got edge=%0d want 12", first);
    end
    drive_keys(4'b1111);
    repeat (15) @(negedge clk);
  endtask

  task automatic test_long();
    int p_at = -1, l_at = -1, l_cnt = 0, short_cnt = 0;
    drive_keys(4'b0111);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !==
          {m_level, m_press, m_rel, m_long}) begin
        n_fail++;
        $display("FAIL long_model got %b/%b/%b/%b want %b/%b/%b/%b",
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long,
                 m_level, m_press, m_rel, m_long);
      end
      if (bus.key_press[3] && p_at < 0) p_at = k;
      if (bus.key_long[3]) begin l_cnt++; if (l_at < 0) l_at = k; end
    end
    n_cmp++;
`ifdef KEY_LONG_PRESS_EN
    if (l_cnt != 1 || l_at - p_at != 30) begin
      n_fail++;
      $display("FAIL long_held got pulses=%0d offset=%0d want pulses=1 offset=30", l_cnt, l_at - p_at);
    end
`else
    if (l_cnt != 0) begin
      n_fail++;
      $display("FAIL long_disabled got pulses=%0d want 0", l_cnt);
    end
`endif
    drive_keys(4'b1111);
    repeat (15) @(negedge clk);
    drive_keys(4'b0111);
    repeat (25) @(negedge clk);
    bus.key_in = 4'b1111;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.key_long[3]) short_cnt++;
    end
    n_cmp++;
    if (short_cnt != 0) begin
      n_fail++;
      $display("FAIL long_short got pulses=%0d want 0", short_cnt);
    end
  endtask

  task automatic test_random();
    int hold[NK];
    logic [NK-1:0] v = '1;
    for (int ch = 0; ch < NK; ch++) hold[ch] = $urandom_range(1, 25);
    repeat (1500) begin
      @(negedge clk);
      for (int ch = 0; ch < NK; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          v[ch] = ~v[ch];
          hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 14);
        end
      end
      bus.key_in = v;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !==
          {m_level, m_press, m_rel, m_long}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 bus.key_level, bus.key_press, bus.key_release, bus.key_long,
                 m_level, m_press, m_rel, m_long);
      end
    end
  endtask

  initial begin
    bus.key_in = '1;
    test_reset();
    test_press_latency();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_long();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
